pw_conv_engine: RTL and testbench

Parametrised pointwise (1×1) convolution engine for the fire-module expand and squeeze paths. It time-multiplexes DSP_NO MAC lanes over CHOUT output channels in CHOUT/DSP_NO groups. The engine consumes a valid/ready activation stream and reads weights and biases from combinational ROMs. It emits bias-added, ReLU'd results one pixel-group at a time through a one-entry, back-pressurable output register.

---
 rtl/pw_conv_pkg.sv | 30 +++
 rtl/pw_conv_lane.sv | 49 ++++
 rtl/pw_conv_engine.sv | 153 +++++++++++++++
 tb/tb_pw_conv_engine.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_conv_pkg.sv
// Shared state type and arithmetic helpers for the pointwise conv engine.
// Define PW_CONV_SAT_EN to clamp positive overflow instead of wrapping.
package pw_conv_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam int MAX_W = 64;

   function automatic int acc_w(input int width, input int chin);
      return 2 * width + $clog2(chin);
   endfunction

   function automatic logic [MAX_W-1:0] relu_sat(
      input logic signed [MAX_W-1:0] y,
      input int                      width
   );
`ifdef PW_CONV_SAT_EN
      logic signed [MAX_W-1:0] lim;
      lim = (64'sd1 <<< (width - 1)) - 64'sd1;
      if (y < 0) return '0;
      if (y > lim) return lim;
      return y;
`else
      if (y < 0) return '0;
      if (width < 1) return '0;
      return y;
`endif
   endfunction

endpackage

// File: rtl/pw_conv_lane.sv
// One MAC lane: accumulate, align bias, shift back to FRAC, ReLU.
// Output clamping follows PW_CONV_SAT_EN through relu_sat.
module pw_conv_lane
   import pw_conv_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int CHIN  = 112
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    first,
   input  logic signed [WIDTH-1:0] act,
   input  logic signed [WIDTH-1:0] weight,
   input  logic signed [WIDTH-1:0] bias,
   output logic        [WIDTH-1:0] res
);

   localparam int ACC_W = acc_w(WIDTH, CHIN);
   localparam int SUM_W = ACC_W + 1;

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   prod_x;
   logic signed [ACC_W-1:0]   bias_x;
   logic signed [ACC_W-1:0]   base;
   logic signed [SUM_W-1:0]   sum;
   logic signed [SUM_W-1:0]   y;

   assign prod   = act * weight;
   assign prod_x = ACC_W'(prod);
   assign bias_x = ACC_W'(bias) <<< FRAC;

   // First channel starts from zero so no clear cycle is needed
   assign base = first ? '0 : acc;
   assign sum  = SUM_W'(base) + SUM_W'(prod_x) + SUM_W'(bias_x);
   assign y    = sum >>> FRAC;
   assign res  = WIDTH'(relu_sat(MAX_W'(y), WIDTH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= first ? prod_x : acc + prod_x;
      end
   end

endmodule

// File: rtl/pw_conv_engine.sv
// Pointwise 1x1 conv engine: DSP_NO lanes swept over CHOUT/DSP_NO groups.
// PW_CONV_SAT_EN (in the lanes) selects saturating instead of wrapping output.
module pw_conv_engine
   import pw_conv_pkg::*;
#(
   parameter  int WIDTH  = 16,
   parameter  int FRAC   = 8,
   parameter  int CHIN   = 112,
   parameter  int CHOUT  = 368,
   parameter  int DSP_NO = 92,
   parameter  int H_IN   = 8,
   parameter  int W_IN   = 8,
   localparam int GROUPS = CHOUT / DSP_NO,
   localparam int NPIX   = H_IN * W_IN,
   localparam int WA_W   = (GROUPS * CHIN > 1) ? $clog2(GROUPS * CHIN) : 1,
   localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1,
   localparam int P_W    = (NPIX > 1) ? $clog2(NPIX) : 1,
   localparam int CH_W   = (CHIN > 1) ? $clog2(CHIN) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [WIDTH-1:0]        ifm,
   input  logic                    ifm_valid,
   output logic                    ifm_ready,
   output logic [WA_W-1:0]         w_addr,
   input  logic [DSP_NO*WIDTH-1:0] w_data,
   output logic [G_W-1:0]          b_addr,
   input  logic [DSP_NO*WIDTH-1:0] b_data,
   output logic [DSP_NO*WIDTH-1:0] ofm,
   output logic                    ofm_valid,
   input  logic                    ofm_ready,
   output logic [G_W-1:0]          ofm_group,
   output logic [P_W-1:0]          ofm_pix,
   output logic                    busy,
   output logic                    done
);

   state_t state_q;
   state_t state_d;

   logic [CH_W-1:0]         ch;
   logic [P_W-1:0]          pix;
   logic [G_W-1:0]          grp;
   logic                    last_ch;
   logic                    last_pix;
   logic                    last_grp;
   logic                    accept;
   logic                    load;
   logic [DSP_NO*WIDTH-1:0] lane_res;

   assign last_ch  = (ch == CH_W'(CHIN - 1));
   assign last_pix = (pix == P_W'(NPIX - 1));
   assign last_grp = (grp == G_W'(GROUPS - 1));

   assign w_addr = WA_W'(int'(grp) * CHIN + int'(ch));
   assign b_addr = grp;

   // Only the final beat of a pixel needs the output slot free
   assign ifm_ready = (state_q == RUN)
                    && !(last_ch && ofm_valid && !ofm_ready);
   assign accept    = ifm_valid && ifm_ready;
   assign load      = accept && last_ch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = RUN;
         end
         RUN: begin
            if (load && last_pix && last_grp) state_d = FLUSH;
         end
         FLUSH: begin
            if (!ofm_valid || ofm_ready) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch  <= '0;
         pix <= '0;
         grp <= '0;
      end else if (state_q == IDLE && start) begin
         ch  <= '0;
         pix <= '0;
         grp <= '0;
      end else if (accept) begin
         if (last_ch) begin
            ch <= '0;
            if (last_pix) begin
               pix <= '0;
               grp <= last_grp ? '0 : grp + G_W'(1);
            end else begin
               pix <= pix + P_W'(1);
            end
         end else begin
            ch <= ch + CH_W'(1);
         end
      end
   end

   for (genvar k = 0; k < DSP_NO; k++) begin : g_lane
      pw_conv_lane #(
         .WIDTH (WIDTH),
         .FRAC  (FRAC),
         .CHIN  (CHIN)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (accept),
         .first  (ch == '0),
         .act    (ifm),
         .weight (w_data[k*WIDTH +: WIDTH]),
         .bias   (b_data[k*WIDTH +: WIDTH]),
         .res    (lane_res[k*WIDTH +: WIDTH])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ofm       <= '0;
         ofm_valid <= 1'b0;
         ofm_group <= '0;
         ofm_pix   <= '0;
      end else if (load) begin
         ofm       <= lane_res;
         ofm_valid <= 1'b1;
         ofm_group <= grp;
         ofm_pix   <= pix;
      end else if (ofm_ready) begin
         ofm_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pw_conv_engine.sv
// Directed bench for pw_conv_engine: arithmetic model plus scoreboard.
// Honours PW_CONV_SAT_EN in its model the same way the design does.
module tb_pw_conv_engine;

   localparam int WIDTH  = 16;
   localparam int FRAC   = 8;
   localparam int CHIN   = 4;
   localparam int CHOUT  = 8;
   localparam int DSP_NO = 4;
   localparam int H_IN   = 2;
   localparam int W_IN   = 2;
   localparam int GROUPS = CHOUT / DSP_NO;
   localparam int NPIX   = H_IN * W_IN;
   localparam int TOTAL  = GROUPS * NPIX * CHIN;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] ifm = '0;
   logic        ifm_valid = 1'b0;
   logic        ofm_ready = 1'b1;
   logic        ifm_ready;
   logic [2:0]  w_addr;
   logic [0:0]  b_addr;
   logic [63:0] w_data;
   logic [63:0] b_data;
   logic [63:0] ofm;
   logic        ofm_valid;
   logic [0:0]  ofm_group;
   logic [1:0]  ofm_pix;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   logic signed [15:0] act  [NPIX][CHIN];
   logic signed [15:0] wrom [GROUPS*CHIN][DSP_NO];
   logic signed [15:0] brom [GROUPS][DSP_NO];

   always_comb begin
      w_data = '0;
      b_data = '0;
      for (int k = 0; k < DSP_NO; k++) begin
         w_data[k*16 +: 16] = wrom[w_addr][k];
         b_data[k*16 +: 16] = brom[b_addr][k];
      end
   end

   pw_conv_engine #(
      .WIDTH (WIDTH), .FRAC (FRAC), .CHIN (CHIN), .CHOUT (CHOUT),
      .DSP_NO (DSP_NO), .H_IN (H_IN), .W_IN (W_IN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ifm       (ifm),
      .ifm_valid (ifm_valid),
      .ifm_ready (ifm_ready),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .ofm       (ofm),
      .ofm_valid (ofm_valid),
      .ofm_ready (ofm_ready),
      .ofm_group (ofm_group),
      .ofm_pix   (ofm_pix),
      .busy      (busy),
      .done      (done)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Dot product over channels, bias in Q.FRAC, floor shift, ReLU
   function automatic logic [15:0] model_lane(int g, int p, int k);
      longint s;
      s = 0;
      for (int c = 0; c < CHIN; c++)
         s += longint'(act[p][c]) * longint'(wrom[g*CHIN+c][k]);
      s += longint'(brom[g][k]) * 256;
      s = s >>> FRAC;
      if (s < 0) s = 0;
`ifdef PW_CONV_SAT_EN
      if (s > 32767) s = 32767;
`endif
      return s[15:0];
   endfunction

   typedef struct {
      int          g;
      int          p;
      logic [63:0] v;
   } exp_t;

   exp_t q[$];
   exp_t e;

   task automatic load_expect();
      exp_t x;
      q.delete();
      for (int g = 0; g < GROUPS; g++)
         for (int p = 0; p < NPIX; p++) begin
            x.g = g;
            x.p = p;
            x.v = '0;
            for (int k = 0; k < DSP_NO; k++)
               x.v[k*16 +: 16] = model_lane(g, p, k);
            q.push_back(x);
         end
   endtask

   int cyc = 0;
   int beats = 0;
   int last_cyc = 0;
   int done_cyc = 0;
   int done_cnt = 0;
   int lat_pix = 0;
   bit pend_lat = 0;
   bit stall_chk = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (pend_lat) begin
            check("ofm_valid_latency", 64'(ofm_valid), 1);
            check("ofm_pix_latency", 64'(ofm_pix), 64'(lat_pix));
            pend_lat = 0;
         end
         if (ofm_valid && ofm_ready) begin
            if (q.size() == 0) begin
               check("unexpected_ofm", 1, 0);
            end else begin
               e = q.pop_front();
               check("ofm_data", ofm, e.v);
               check("ofm_group", 64'(ofm_group), 64'(e.g));
               check("ofm_pix", 64'(ofm_pix), 64'(e.p));
            end
         end
         if (stall_chk && busy && ifm_valid && !ifm_ready) begin
            check("stall_beat", 64'(beats), 7);
            stall_chk = 0;
         end
         if (ifm_valid && ifm_ready) begin
            if (beats % CHIN == CHIN - 1) begin
               pend_lat = 1;
               lat_pix  = (beats / CHIN) % NPIX;
            end
            beats++;
            if (beats == TOTAL) last_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   bit stall_mode = 0;
   bit seen = 0;
   int scnt = 0;

   always @(posedge clk) begin
      #1;
      if (!stall_mode) begin
         seen      = 0;
         ofm_ready = 1'b1;
      end else begin
         if (!seen && ofm_valid) begin
            seen = 1;
            scnt = 10;
         end
         ofm_ready = seen && scnt == 0;
         if (seen && scnt > 0) scnt--;
      end
   end

   task automatic run_layer(input int n, input bit gaps, input int pulse_at);
      int to;
      bit rdy;
      load_expect();
      beats    = 0;
      done_cnt = 0;
      pend_lat = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 64'(busy), 1);
      for (int i = 0; i < n; i++) begin
         if (gaps)
            while ($urandom_range(0, 1) == 1) begin
               ifm_valid = 1'b0;
               @(posedge clk); #1;
            end
         ifm       = act[(i / CHIN) % NPIX][i % CHIN];
         ifm_valid = 1'b1;
         if (i == pulse_at) start = 1'b1;
         to  = 0;
         rdy = 0;
         do begin
            @(negedge clk);
            rdy = ifm_ready;
            @(posedge clk); #1;
            start = 1'b0;
            to++;
         end while (!rdy && to < 100);
         if (!rdy) begin
            check("beat_timeout", 0, 1);
            break;
         end
      end
      ifm_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && done_cnt == 0; i++) begin
         @(negedge clk); #1;
      end
      check("done_seen", 64'(done_cnt), 1);
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("done_single", 64'(done_cnt), 1);
      check("idle_busy", 64'(busy), 0);
      check("queue_empty", 64'(q.size()), 0);
   endtask

   task automatic fill(input logic [15:0] a, input logic [15:0] w);
      for (int p = 0; p < NPIX; p++)
         for (int c = 0; c < CHIN; c++) act[p][c] = a;
      for (int r = 0; r < GROUPS*CHIN; r++)
         for (int k = 0; k < DSP_NO; k++) wrom[r][k] = w;
      for (int g = 0; g < GROUPS; g++)
         for (int k = 0; k < DSP_NO; k++) brom[g][k] = '0;
   endtask

   task automatic fill_varied();
      for (int p = 0; p < NPIX; p++)
         for (int c = 0; c < CHIN; c++)
            act[p][c] = 16'(((p*5 + c*3) % 11 - 4) * 48);
      for (int r = 0; r < GROUPS*CHIN; r++)
         for (int k = 0; k < DSP_NO; k++)
            wrom[r][k] = 16'(((r*7 + k*3) % 13 - 5) * 40);
      for (int g = 0; g < GROUPS; g++)
         for (int k = 0; k < DSP_NO; k++)
            brom[g][k] = 16'(((g*3 + k) % 5) * 100 - 150);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ofm"}, ofm, 0);
      check({tag, "_ofm_valid"}, 64'(ofm_valid), 0);
      check({tag, "_ofm_group"}, 64'(ofm_group), 0);
      check({tag, "_ofm_pix"}, 64'(ofm_pix), 0);
      check({tag, "_ifm_ready"}, 64'(ifm_ready), 0);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
   endtask

   initial begin
      fill(16'h0000, 16'h0000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // Unity-ish data: four channels of 1.0*1.0 give 4.0
      fill(16'h0100, 16'h0100);
      check("model_unity", 64'(model_lane(1, 3, 2)), 64'h0400);
      run_layer(TOTAL, 0, -1);
      wait_done();
      check("done_latency", 64'(done_cyc - last_cyc), 2);

      // Bias only: positive passes, negative is cut by ReLU
      fill(16'h0000, 16'h0100);
      for (int g = 0; g < GROUPS; g++) begin
         brom[g][2] = 16'h0080;
         brom[g][3] = 16'hFF80;
      end
      check("model_bias_pos", 64'(model_lane(0, 0, 2)), 64'h0080);
      check("model_bias_neg", 64'(model_lane(0, 0, 3)), 64'h0000);
      run_layer(TOTAL, 0, -1);
      wait_done();

      // Full-scale products overflow the output width
      fill(16'h7FFF, 16'h7FFF);
`ifdef PW_CONV_SAT_EN
      check("model_overflow", 64'(model_lane(0, 1, 0)), 64'h7FFF);
`else
      check("model_overflow", 64'(model_lane(0, 1, 0)), 64'hFC00);
`endif
      run_layer(TOTAL, 0, -1);
      wait_done();

      // Output back-pressure holds the last beat of pixel 1
      fill_varied();
      stall_mode = 1;
      stall_chk  = 1;
      run_layer(TOTAL, 0, -1);
      wait_done();
      check("stall_seen", 64'(stall_chk), 0);
      stall_mode = 0;
      stall_chk  = 0;

      // Random input gaps must not change the results
      run_layer(TOTAL, 1, -1);
      wait_done();

      // Abort mid-layer, then a clean restart with a stray start
      run_layer(13, 0, -1);
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("abort");
      q.delete();
      pend_lat = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("post_abort");
      run_layer(TOTAL, 0, 10);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
